// File: rtl/multdiv_ctrl_pkg.sv
// Purpose: shared ISA constants, sequencer state encoding and decode helpers for the mul/div sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multdiv_ctrl_pkg;

    // Major opcode field insn[31:27] and ALU-op field insn[6:2]
    localparam logic [4:0] OPC_R_TYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL    = 5'b00110;
    localparam logic [4:0] ALU_DIV    = 5'b00111;

    // Codes written to $r30 when the unit flags overflow / divide-by-zero
    localparam int EXC_MUL = 4;
    localparam int EXC_DIV = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    typedef struct packed {
        logic is_mul;
        logic is_div;
        logic is_md;
    } md_dec_t;

    function automatic md_dec_t md_decode(input logic [4:0] opcode, input logic [4:0] alu_op);
        md_dec_t d;
        d.is_mul = (opcode == OPC_R_TYPE) && (alu_op == ALU_MUL);
        d.is_div = (opcode == OPC_R_TYPE) && (alu_op == ALU_DIV);
        d.is_md  = d.is_mul | d.is_div;
        return d;
    endfunction

    function automatic logic [2:0] exc_code(input logic op_div);
        return op_div ? 3'(EXC_DIV) : 3'(EXC_MUL);
    endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Purpose: launch/operand/result bundle between the sequencer and the shared mul/div unit.
// Latency: n/a (wiring only).
// Backpressure: unit holds md_ready low until its result is valid; no other flow control.
interface multdiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             md_start_mult;
    logic             md_start_div;
    logic [WIDTH-1:0] md_op_a;
    logic [WIDTH-1:0] md_op_b;
    logic             md_ready;
    logic [WIDTH-1:0] md_result;
    logic             md_exception;

    modport master (
        output md_start_mult,
        output md_start_div,
        output md_op_a,
        output md_op_b,
        input  md_ready,
        input  md_result,
        input  md_exception
    );

    modport slave (
        input  md_start_mult,
        input  md_start_div,
        input  md_op_a,
        input  md_op_b,
        output md_ready,
        output md_result,
        output md_exception
    );
endinterface

// File: rtl/multdiv_ctrl_md_cycle_counter.sv
// Purpose: counts BUSY cycles; saturates at TERMINAL and flags it.
// Latency: count updates one cycle after enable; tc is combinational from count.
// Backpressure: none; clear wins over enable.
module md_cycle_counter #(
    parameter int CNT_W    = 6,
    parameter int TERMINAL = 39
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == CNT_W'(TERMINAL));

    // Count enabled cycles, holding at the terminal value so it never wraps
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Purpose: sequences mul/div in X onto the shared multi-cycle unit, stalling F/D/X until done (optional MULTDIV_TIMEOUT_EN).
// Latency: launch cycle + N BUSY cycles + one DONE cycle carrying the result (minimum 3 cycles).
// Backpressure: stall held while launching and in BUSY; flush aborts, reset returns to IDLE.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      insn_x,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    multdiv_ctrl_if.master   md,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             write_exception,
    output logic             busy
);

    md_state_e        state_q;
    md_state_e        state_d;
    md_dec_t          dec;
    logic             launch;
    logic             cap_en;
    logic [WIDTH-1:0] cap_res_d;
    logic             cap_exc_d;
    logic [WIDTH-1:0] cap_res_q;
    logic             cap_exc_q;
    logic             op_div_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             timeout_hit;
    logic             unused_cnt;
    logic             unused_insn;

    assign dec         = md_decode(insn_x[31:27], insn_x[6:2]);
    assign unused_insn = ^{insn_x[26:7], insn_x[1:0]};

    md_cycle_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (launch),
        .enable (busy),
        .count  (cnt),
        .tc     (cnt_tc)
    );

    // The counter reaching TIMEOUT_CYCLES-1 in a BUSY cycle means this is the last tolerated cycle
`ifdef MULTDIV_TIMEOUT_EN
    assign timeout_hit = cnt_tc;
    assign unused_cnt  = ^cnt;
`else
    assign timeout_hit = 1'b0;
    assign unused_cnt  = ^{cnt, cnt_tc};
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, launch, capture and pipeline-facing strobes
    always_comb begin
        state_d      = state_q;
        launch       = 1'b0;
        cap_en       = 1'b0;
        cap_res_d    = cap_res_q;
        cap_exc_d    = cap_exc_q;
        stall        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (dec.is_md && !flush) begin
                    launch  = 1'b1;
                    stall   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                busy  = 1'b1;
                // A squashed instruction must never write back, even if the unit finishes now
                if (flush) begin
                    state_d = IDLE;
                end else if (md.md_ready) begin
                    cap_en    = 1'b1;
                    cap_res_d = md.md_result;
                    cap_exc_d = md.md_exception;
                    state_d   = DONE;
                end else if (timeout_hit) begin
                    cap_en    = 1'b1;
                    cap_exc_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // Stall drops here so the insn leaves X and is not relaunched
                result_valid = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand/op latch at launch and result capture at completion
    always_ff @(posedge clock) begin
        if (reset) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_div_q  <= 1'b0;
            cap_res_q <= '0;
            cap_exc_q <= 1'b0;
        end else begin
            if (launch) begin
                op_a_q   <= operand_a;
                op_b_q   <= operand_b;
                op_div_q <= dec.is_div;
            end
            if (cap_en) begin
                cap_res_q <= cap_res_d;
                cap_exc_q <= cap_exc_d;
            end
        end
    end

    assign md.md_start_mult = launch & dec.is_mul;
    assign md.md_start_div  = launch & dec.is_div;
    assign md.md_op_a       = op_a_q;
    assign md.md_op_b       = op_b_q;

    assign result = !result_valid ? '0
                  : cap_exc_q     ? WIDTH'(exc_code(op_div_q))
                  :                 cap_res_q;
    assign write_exception = result_valid & cap_exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Purpose: directed scoreboard bench for multdiv_ctrl; bench drives the unit side of the interface.
// Latency: results checked whenever result_valid is seen, against a queue filled at issue time.
// Backpressure: md_ready is driven by the bench after a chosen number of BUSY cycles.
module tb_multdiv_ctrl;

    localparam int W = 32;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] INSN_MUL = 32'h0062_0818;
    localparam logic [31:0] INSN_DIV = 32'h00a4_101c;
    localparam logic [31:0] INSN_ADD = 32'h0062_0800;
    localparam logic [31:0] INSN_NRT = 32'h2862_0818;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   insn_x;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic          flush;
    logic          stall;
    logic          result_valid;
    logic [W-1:0]  result;
    logic          write_exception;
    logic          busy;

    multdiv_ctrl_if #(.WIDTH(W)) md();

    multdiv_ctrl #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (40),
        .CNT_W          (6)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .insn_x          (insn_x),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .flush           (flush),
        .md              (md),
        .stall           (stall),
        .result_valid    (result_valid),
        .result          (result),
        .write_exception (write_exception),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    logic prev_rv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every result presented to X/M must match the oldest issued expectation
    always @(negedge clock) begin
        if (result_valid === 1'b1) begin
            chk("rv_single_cycle", 32'(prev_rv), 0);
            chk("rv_no_stall", 32'(stall), 0);
            chk("rv_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("result", result, mon_e.res);
                chk("write_exception", 32'(write_exception), 32'(mon_e.exc));
            end
        end
        prev_rv = result_valid;
    end

    task automatic idle_chk(input string tag);
        @(negedge clock);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_start"}, 32'({md.md_start_mult, md.md_start_div}), 0);
        chk({tag, "_rv"}, 32'(result_valid), 0);
        chk({tag, "_result"}, result, 0);
        @(posedge clock); #1;
    endtask

    task automatic all_zero_chk(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rv"}, 32'(result_valid), 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_wexc"}, 32'(write_exception), 0);
        chk({tag, "_start"}, 32'({md.md_start_mult, md.md_start_div}), 0);
        chk({tag, "_op_a"}, md.md_op_a, 0);
        chk({tag, "_op_b"}, md.md_op_b, 0);
    endtask

    // Issue one mul/div; the unit answers in BUSY cycle nbusy
    task automatic mdop(input logic [31:0] insn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int nbusy, input logic [W-1:0] unit_res, input logic unit_exc,
                        input logic [W-1:0] exp_res, input logic exp_exc, input logic is_div,
                        input string tag);
        int stalls;
        int extra;
        exp_t e;
        stalls = 0;
        extra  = 0;
        e.res  = exp_res;
        e.exc  = exp_exc;
        exp_q.push_back(e);
        insn_x    = insn;
        operand_a = a;
        operand_b = b;
        @(negedge clock);
        chk({tag, "_launch_stall"}, 32'(stall), 1);
        chk({tag, "_start_mult"}, 32'(md.md_start_mult), 32'(!is_div));
        chk({tag, "_start_div"}, 32'(md.md_start_div), 32'(is_div));
        @(posedge clock); #1;
        operand_a = ~a;
        operand_b = ~b;
        for (int k = 1; k <= nbusy; k++) begin
            md.md_ready     = (k == nbusy);
            md.md_result    = unit_res;
            md.md_exception = unit_exc;
            @(negedge clock);
            stalls += int'(stall);
            extra  += int'(md.md_start_mult | md.md_start_div);
            if (k == nbusy) begin
                chk({tag, "_op_a"}, md.md_op_a, a);
                chk({tag, "_op_b"}, md.md_op_b, b);
                chk({tag, "_busy"}, 32'(busy), 1);
            end
            @(posedge clock); #1;
        end
        md.md_ready     = 1'b0;
        md.md_result    = '0;
        md.md_exception = 1'b0;
        @(negedge clock);
        chk({tag, "_done_busy"}, 32'(busy), 0);
        chk({tag, "_busy_stall_cycles"}, 32'(stalls), 32'(nbusy));
        chk({tag, "_extra_starts"}, 32'(extra), 0);
        @(posedge clock); #1;
        insn_x    = NOP;
        operand_a = '0;
        operand_b = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        reset           = 1'b1;
        insn_x          = NOP;
        operand_a       = '0;
        operand_b       = '0;
        flush           = 1'b0;
        md.md_ready     = 1'b0;
        md.md_result    = '0;
        md.md_exception = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        all_zero_chk("reset");
        @(posedge clock); #1;

        // Non-md instructions and a flushed mul leave the block transparent
        insn_x = INSN_ADD;
        idle_chk("nonmd_add");
        insn_x = INSN_NRT;
        idle_chk("nonrtype_mulbits");
        insn_x = INSN_MUL;
        flush  = 1'b1;
        idle_chk("mul_flushed_in_x");
        flush  = 1'b0;
        insn_x = NOP;

        mdop(INSN_MUL, 6, 7, 5, 42, 1'b0, 42, 1'b0, 1'b0, "mul6x7");
        mdop(INSN_DIV, 10, 0, 3, 32'hFFFF_FFFF, 1'b1, 5, 1'b1, 1'b1, "div0");
        mdop(INSN_MUL, 32'h8000_0000, 2, 2, 0, 1'b1, 4, 1'b1, 1'b0, "mulovf");
        mdop(INSN_MUL, 3, 5, 2, 15, 1'b0, 15, 1'b0, 1'b0, "b2b_1");
        mdop(INSN_MUL, 32'h1234, 32'h10, 1, 32'h12340, 1'b0, 32'h12340, 1'b0, 1'b0, "b2b_2");
        mdop(INSN_DIV, 100, 7, 4, 14, 1'b0, 14, 1'b0, 1'b1, "div100");

        // md_ready outside BUSY is ignored
        md.md_ready  = 1'b1;
        md.md_result = 99;
        idle_chk("ready_in_idle");
        md.md_ready  = 1'b0;
        md.md_result = '0;

        // Flush in the 2nd BUSY cycle beats md_ready
        insn_x    = INSN_MUL;
        operand_a = 3;
        operand_b = 3;
        @(negedge clock);
        chk("flush_start_mult", 32'(md.md_start_mult), 1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("flush_busy1", 32'(busy), 1);
        @(posedge clock); #1;
        flush        = 1'b1;
        md.md_ready  = 1'b1;
        md.md_result = 9;
        @(negedge clock);
        chk("flush_busy2_stall", 32'(stall), 1);
        @(posedge clock); #1;
        flush        = 1'b0;
        md.md_ready  = 1'b0;
        md.md_result = '0;
        insn_x       = NOP;
        @(negedge clock);
        chk("flush_after_busy", 32'(busy), 0);
        chk("flush_after_stall", 32'(stall), 0);
        chk("flush_after_rv", 32'(result_valid), 0);
        @(posedge clock); #1;
        idle_chk("flush_settled");

        // Reset in the middle of BUSY
        insn_x    = INSN_DIV;
        operand_a = 50;
        operand_b = 5;
        @(negedge clock);
        chk("rst_start_div", 32'(md.md_start_div), 1);
        @(posedge clock); #1;
        reset  = 1'b1;
        insn_x = NOP;
        @(negedge clock);
        chk("rst_busy_before", 32'(busy), 1);
        @(posedge clock); #1;
        reset        = 1'b0;
        md.md_ready  = 1'b1;
        md.md_result = 10;
        @(negedge clock);
        all_zero_chk("rst_mid_busy");
        @(posedge clock); #1;
        idle_chk("ready_after_reset");
        md.md_ready  = 1'b0;
        md.md_result = '0;

        // Unit that never answers
        nb = 0;
`ifdef MULTDIV_TIMEOUT_EN
        begin
            exp_t e;
            bit   seen;
            e.res = 5;
            e.exc = 1'b1;
            exp_q.push_back(e);
            seen = 1'b0;
            insn_x    = INSN_DIV;
            operand_a = 9;
            operand_b = 3;
            @(negedge clock);
            chk("to_start_div", 32'(md.md_start_div), 1);
            @(posedge clock); #1;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clock);
                if (busy) nb++;
                else seen = 1'b1;
                if (!seen) begin
                    @(posedge clock); #1;
                end
            end
            chk("timeout_busy_cycles", 32'(nb), 40);
            @(posedge clock); #1;
            insn_x = NOP;
        end
`else
        insn_x    = INSN_DIV;
        operand_a = 9;
        operand_b = 3;
        @(negedge clock);
        chk("hang_start_div", 32'(md.md_start_div), 1);
        @(posedge clock); #1;
        repeat (60) begin
            @(negedge clock);
            nb += int'(stall);
        end
        chk("hang_stall_cycles", 32'(nb), 60);
        @(posedge clock); #1;
        reset  = 1'b1;
        insn_x = NOP;
        @(posedge clock); #1;
        reset = 1'b0;
        idle_chk("after_hang_reset");
`endif

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer that shares one multi-cycle multiply/divide unit with the execute stage.
- Decodes mul/div in X and latches the bypassed operands.
- Launches the unit with a one-cycle start pulse and stalls F/D/X until the unit reports ready.
- Returns the result, or the exception code, for the X/M latch.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- TIMEOUT_CYCLES, 40, BUSY cycles tolerated before forced completion (only used with timeout feature).
- CNT_W, 6, width of the BUSY cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- insn_x  in  32  instruction currently in execute
- operand_a  in  WIDTH  rs value after MX/WX bypass muxing
- operand_b  in  WIDTH  rt value after MX/WX bypass muxing
- flush  in  1  squash X (taken branch/jump); aborts pending op
- md_ready  in  1  unit result valid this cycle
- md_result  in  WIDTH  unit result
- md_exception  in  1  unit overflow / divide-by-zero
- md_start_mult  out  1  one-cycle multiply launch pulse
- md_start_div  out  1  one-cycle divide launch pulse
- md_op_a  out  WIDTH  latched operand A, stable while BUSY
- md_op_b  out  WIDTH  latched operand B, stable while BUSY
- stall  out  1  hold PC, F/D and D/X latches; insert bubble into X/M
- result_valid  out  1  result for X/M latch this cycle
- result  out  WIDTH  product/quotient, or exception code
- write_exception  out  1  result is an exception code (write $r30)
- busy  out  1  state == BUSY

Behaviour:
- Decode: is_mul = insn_x[31:27]==00000 & insn_x[6:2]==00110; is_div = same opcode & insn_x[6:2]==00111; is_md = is_mul | is_div.
- States: IDLE, BUSY, DONE. Reset sets state=IDLE and cnt=0. Reset also clears md_op_a, md_op_b, captured result, captured exception and op flag. All outputs read 0 after reset.
- IDLE:
  - If is_md & ~flush: latch operand_a/b into md_op_a/b and latch op (mul/div).
  - Assert md_start_mult or md_start_div for this cycle only, clear cnt, go to BUSY.
  - stall is combinational and is 1 in this cycle: stall = (IDLE & is_md & ~flush) | BUSY.
- BUSY:
  - stall=1, cnt increments each cycle.
  - md_ready=1: capture md_result and md_exception, go to DONE. md_ready is accepted from the first BUSY cycle onward.
  - flush=1: abort, go to IDLE, no result, capture discarded. Flush has priority over md_ready in the same cycle.
- DONE:
  - stall=0, result_valid=1 for exactly one cycle, then unconditionally to IDLE. The insn in X advances this cycle, so it is never relaunched.
  - result = captured exception ? (mul ? 4 : 5) : captured result.
  - write_exception = captured exception.
- md_ready while in IDLE or DONE is ignored.
- Back-to-back mul/div: a new launch occurs in the IDLE cycle following DONE. Minimum occupancy is 3 cycles (IDLE launch, BUSY, DONE).
- Non-md instructions: stall=0 and result_valid=0; block is transparent.
- md_op_a/b hold their value outside BUSY; the unit may ignore them.
- Reset mid-BUSY: IDLE next cycle, no pulse, no result.

Optional Feature:
- Macro: MULTDIV_TIMEOUT_EN.
- Defined: in BUSY, if cnt reaches TIMEOUT_CYCLES with no md_ready, go to DONE with captured exception=1. result becomes the code for the op (4 or 5), write_exception=1.
- Undefined: BUSY waits indefinitely for md_ready; cnt is not compared and may be optimised away.

Decomposition:
- Shared package (isa_pkg): opcode constants (R_TYPE=00000), ALU op constants (MUL=00110, DIV=00111), exception codes (EXC_MUL=4, EXC_DIV=5), state enum (IDLE/BUSY/DONE).
- One sub-module: md_cycle_counter (clear, enable, count output, terminal-count flag).

Test Plan:
- mul insn, a=6, b=7, md_ready after 5 BUSY cycles with 42 -> md_start_mult pulses once; stall high 6 cycles; result_valid=1, result=42, write_exception=0 in DONE.
- div, a=10, b=0, unit returns md_exception=1 -> result=5, write_exception=1, result_valid for one cycle.
- mul launched, flush asserted on 2nd BUSY cycle, md_ready the same cycle -> IDLE next cycle; no result_valid; stall low.
- Two consecutive mul insns -> two start pulses separated by DONE+IDLE cycles; each result_valid single-cycle; operands of the second latched correctly.
- reset asserted mid-BUSY -> next cycle all outputs 0, state IDLE; later md_ready ignored.
- With MULTDIV_TIMEOUT_EN, div with md_ready never asserted -> after 40 BUSY cycles, result=5, write_exception=1; without the macro, stall stays high.
